// File: rtl/m2_block_writer.sv
// rtl/m2_block_writer.sv - IDCT write-back: clip, pack and store 8x8 blocks to SRAM
//
// Reads the 64 signed IDCT results of one 8x8 block from the sample RAM,
// clips each to 8 bits, packs two pixels per word and writes the 32 words
// to their row-major SRAM locations. Block position is tracked across the
// Y, U and V segments; after the final V block the writer parks until Reset.
//
// Ports:
//   Clock           in   system clock
//   Reset           in   synchronous, active-high reset
//   start           in   one-cycle pulse, sample RAM holds a complete block
//   S_rd_data       in   signed sample, valid one cycle after S_rd_addr
//   S_rd_addr       out  sample RAM read address (r*8+c)
//   SRAM_address    out  SRAM word address
//   SRAM_write_data out  packed pixel pair {even col, odd col}
//   SRAM_we_n       out  active-low SRAM write strobe
//   busy            out  high from accept to done
//   done            out  one-cycle pulse, block fully written
//   all_done        out  high after the last V block, held until Reset
//   seg             out  current segment: 0=Y, 1=U, 2=V

module m2_block_writer #(
    parameter int unsigned Y_BASE      = 0,
    parameter int unsigned U_BASE      = 38400,
    parameter int unsigned V_BASE      = 57600,
    parameter int unsigned Y_BLK_COLS  = 40,
    parameter int unsigned UV_BLK_COLS = 20,
    parameter int unsigned BLK_ROWS    = 30
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] S_rd_data,
    output logic [5:0]  S_rd_addr,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        busy,
    output logic        done,
    output logic        all_done,
    output logic [1:0]  seg
);

    // Word strides of one pixel row, and of one block row (8 pixel rows).
    localparam logic [17:0] Y_STRIDE    = 18'(Y_BLK_COLS * 4);
    localparam logic [17:0] UV_STRIDE   = 18'(UV_BLK_COLS * 4);
    localparam logic [17:0] Y_ROW_STEP  = 18'(Y_BLK_COLS * 32);
    localparam logic [17:0] UV_ROW_STEP = 18'(UV_BLK_COLS * 32);
    localparam logic [7:0]  Y_COL_LAST  = 8'(Y_BLK_COLS - 1);
    localparam logic [7:0]  UV_COL_LAST = 8'(UV_BLK_COLS - 1);
    localparam logic [7:0]  ROW_LAST    = 8'(BLK_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE,
        S_FINISHED
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  rd_cnt_q;
    logic        vld_q;          // S_rd_data carries a sample this cycle
    logic [2:0]  idx_q;          // low bits of that sample's index (c of r*8+c)
    logic [7:0]  even_q;         // clipped even-column pixel awaiting its pair
    logic [17:0] line_q;         // address of word 0 of the current pixel row
    logic [17:0] blk_base_q;     // address of word 0 of the current block
    logic [17:0] row_base_q;     // address of word 0 of the current block row
    logic [17:0] addr_hold_q;
    logic [15:0] data_hold_q;
    logic        busy_q;
    logic        all_done_q;
    logic [1:0]  seg_q;
    logic [7:0]  brow_q;
    logic [7:0]  bcol_q;

    logic        wr_en;
    logic [7:0]  pix;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic [17:0] stride;
    logic [17:0] row_step;
    logic        col_last;
    logic        row_last;
    logic        last_blk;

    function automatic logic [7:0] clip8(input logic [15:0] s);
        if (s[15]) begin
            return 8'h00;
        end else if (|s[14:8]) begin
            return 8'hFF;
        end else begin
            return s[7:0];
        end
    endfunction

    always_comb begin
        pix      = clip8(S_rd_data);
        // An odd-column sample completes a pair, so the word goes out in the
        // same cycle that sample arrives from the RAM.
        wr_en    = vld_q & idx_q[0];
        wr_addr  = line_q + {16'd0, idx_q[2:1]};
        wr_data  = {even_q, pix};
        stride   = (seg_q == 2'd0) ? Y_STRIDE : UV_STRIDE;
        row_step = (seg_q == 2'd0) ? Y_ROW_STEP : UV_ROW_STEP;
        col_last = (bcol_q == ((seg_q == 2'd0) ? Y_COL_LAST : UV_COL_LAST));
        row_last = (brow_q == ROW_LAST);
        last_blk = (seg_q == 2'd2) && row_last && col_last;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_READ;
            S_READ:     if (rd_cnt_q == 6'd63) state_d = S_DRAIN;
            S_DRAIN:    state_d = S_DONE;
            S_DONE:     state_d = last_blk ? S_FINISHED : S_IDLE;
            S_FINISHED: state_d = S_FINISHED;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= 6'd0;
            vld_q       <= 1'b0;
            idx_q       <= 3'd0;
            even_q      <= 8'd0;
            line_q      <= 18'(Y_BASE);
            blk_base_q  <= 18'(Y_BASE);
            row_base_q  <= 18'(Y_BASE);
            addr_hold_q <= 18'd0;
            data_hold_q <= 16'd0;
            busy_q      <= 1'b0;
            all_done_q  <= 1'b0;
            seg_q       <= 2'd0;
            brow_q      <= 8'd0;
            bcol_q      <= 8'd0;
        end else begin
            state_q <= state_d;
            vld_q   <= (state_q == S_READ);
            idx_q   <= rd_cnt_q[2:0];

            // Wraps back to 0 after address 63, ready for the next block.
            if (state_q == S_READ) begin
                rd_cnt_q <= rd_cnt_q + 6'd1;
            end

            if (state_q == S_IDLE && start) begin
                busy_q <= 1'b1;
                line_q <= blk_base_q;
            end

            if (vld_q && !idx_q[0]) begin
                even_q <= pix;
            end

            if (wr_en) begin
                addr_hold_q <= wr_addr;
                data_hold_q <= wr_data;
                // Last word of a pixel row: step down one image row.
                if (idx_q[2:1] == 2'b11) begin
                    line_q <= line_q + stride;
                end
            end

            if (state_q == S_DONE) begin
                busy_q <= 1'b0;
                if (last_blk) begin
                    all_done_q <= 1'b1;
                end else if (!col_last) begin
                    bcol_q     <= bcol_q + 8'd1;
                    blk_base_q <= blk_base_q + 18'd4;
                end else if (!row_last) begin
                    bcol_q     <= 8'd0;
                    brow_q     <= brow_q + 8'd1;
                    row_base_q <= row_base_q + row_step;
                    blk_base_q <= row_base_q + row_step;
                end else begin
                    bcol_q     <= 8'd0;
                    brow_q     <= 8'd0;
                    seg_q      <= seg_q + 2'd1;
                    row_base_q <= (seg_q == 2'd0) ? 18'(U_BASE) : 18'(V_BASE);
                    blk_base_q <= (seg_q == 2'd0) ? 18'(U_BASE) : 18'(V_BASE);
                end
            end
        end
    end

    assign S_rd_addr       = rd_cnt_q;
    assign SRAM_address    = wr_en ? wr_addr : addr_hold_q;
    assign SRAM_write_data = wr_en ? wr_data : data_hold_q;
    assign SRAM_we_n       = ~wr_en;
    assign busy            = busy_q;
    assign done            = (state_q == S_DONE);
    assign all_done        = all_done_q;
    assign seg             = seg_q;

endmodule

// File: tb/tb_m2_block_writer.sv
// tb/tb_m2_block_writer.sv - directed table-driven bench for m2_block_writer

module tb_m2_block_writer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        Reset;
    logic        start_r;
    logic        sel;          // 0: full-size instance A, 1: small instance B
    logic        a_start, b_start;
    logic [15:0] a_rd_data, b_rd_data;
    logic [5:0]  a_rd_addr, b_rd_addr;
    logic [17:0] a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic        a_we_n, b_we_n, a_busy, b_busy, a_done, b_done, a_all, b_all;
    logic [1:0]  a_seg, b_seg;

    logic [17:0] m_addr;
    logic [15:0] m_data;
    logic [5:0]  m_rd_addr;
    logic        m_we_n, m_busy, m_done, m_all;
    logic [1:0]  m_seg;

    logic [15:0] mem [64];

    assign a_start   = start_r & ~sel;
    assign b_start   = start_r & sel;
    assign m_addr    = sel ? b_addr : a_addr;
    assign m_data    = sel ? b_data : a_data;
    assign m_rd_addr = sel ? b_rd_addr : a_rd_addr;
    assign m_we_n    = sel ? b_we_n : a_we_n;
    assign m_busy    = sel ? b_busy : a_busy;
    assign m_done    = sel ? b_done : a_done;
    assign m_all     = sel ? b_all : a_all;
    assign m_seg     = sel ? b_seg : a_seg;

    always @(posedge clk) begin
        a_rd_data <= mem[a_rd_addr];
        b_rd_data <= mem[b_rd_addr];
    end

    m2_block_writer dut_a (
        .Clock(clk), .Reset(Reset), .start(a_start), .S_rd_data(a_rd_data),
        .S_rd_addr(a_rd_addr), .SRAM_address(a_addr), .SRAM_write_data(a_data),
        .SRAM_we_n(a_we_n), .busy(a_busy), .done(a_done), .all_done(a_all),
        .seg(a_seg)
    );

    m2_block_writer #(
        .Y_BASE(0), .U_BASE(1000), .V_BASE(2000),
        .Y_BLK_COLS(3), .UV_BLK_COLS(2), .BLK_ROWS(2)
    ) dut_b (
        .Clock(clk), .Reset(Reset), .start(b_start), .S_rd_data(b_rd_data),
        .S_rd_addr(b_rd_addr), .SRAM_address(b_addr), .SRAM_write_data(b_data),
        .SRAM_we_n(b_we_n), .busy(b_busy), .done(b_done), .all_done(b_all),
        .seg(b_seg)
    );

    int total = 0;
    int bad   = 0;

    logic [17:0] w_addr [32];
    logic [15:0] w_data [32];
    int          w_cyc  [32];
    int          w_cnt, done_cyc, rd_err;
    logic [1:0]  seg_at;

    typedef struct {
        int          blk;
        int          word;
        logic [17:0] addr;
        logic [15:0] data;
    } vec_a_t;

    typedef struct {
        int          blk;
        int          word;
        logic [17:0] addr;
        logic [1:0]  seg;
    } vec_b_t;

    vec_a_t va [14];
    vec_b_t vb [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_mem(input int blk);
        for (int k = 0; k < 64; k++) mem[k] = 16'(k);
        if (blk == 1) begin
            mem[0] = -16'sd5;
            mem[1] = 16'd300;
            mem[2] = 16'd255;
            mem[3] = 16'd0;
            mem[4] = 16'd256;
            mem[5] = 16'h8000;
            mem[6] = 16'h7FFF;
            mem[7] = 16'd128;
        end
    endtask

    // Starts one block and logs every write; cycle n is the period ending at
    // edge E0+n. A second start is pulsed at cycle ign_at (0 = none).
    task automatic run_block(input int ign_at);
        w_cnt    = 0;
        done_cyc = -1;
        rd_err   = 0;
        seg_at   = 2'd3;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start_r = (n == ign_at);
            if (n <= 64 && m_rd_addr != 6'(n - 1)) rd_err++;
            if (!m_we_n) begin
                if (w_cnt < 32) begin
                    w_addr[w_cnt] = m_addr;
                    w_data[w_cnt] = m_data;
                    w_cyc[w_cnt]  = n;
                end
                if (w_cnt == 0) seg_at = m_seg;
                w_cnt++;
            end
            if (m_done) begin
                done_cyc = n;
                break;
            end
        end
        start_r = 1'b0;
    endtask

    initial begin
        int cur;
        int errs;

        va[0]  = '{0, 0, 18'd0, 16'h0001};
        va[1]  = '{0, 1, 18'd1, 16'h0203};
        va[2]  = '{0, 2, 18'd2, 16'h0405};
        va[3]  = '{0, 3, 18'd3, 16'h0607};
        va[4]  = '{0, 4, 18'd160, 16'h0809};
        va[5]  = '{0, 31, 18'd1123, 16'h3E3F};
        va[6]  = '{1, 0, 18'd4, 16'h00FF};
        va[7]  = '{1, 1, 18'd5, 16'hFF00};
        va[8]  = '{1, 2, 18'd6, 16'hFF00};
        va[9]  = '{1, 3, 18'd7, 16'hFF80};
        va[10] = '{1, 4, 18'd164, 16'h0809};
        va[11] = '{39, 0, 18'd156, 16'h0001};
        va[12] = '{40, 0, 18'd1280, 16'h0001};
        va[13] = '{40, 31, 18'd2403, 16'h3E3F};

        vb[0] = '{0, 0, 18'd0, 2'd0};
        vb[1] = '{3, 0, 18'd96, 2'd0};
        vb[2] = '{5, 31, 18'd191, 2'd0};
        vb[3] = '{6, 0, 18'd1000, 2'd1};
        vb[4] = '{7, 0, 18'd1004, 2'd1};
        vb[5] = '{8, 0, 18'd1064, 2'd1};
        vb[6] = '{9, 31, 18'd1127, 2'd1};
        vb[7] = '{10, 0, 18'd2000, 2'd2};
        vb[8] = '{13, 0, 18'd2068, 2'd2};
        vb[9] = '{13, 31, 18'd2127, 2'd2};

        sel     = 1'b0;
        set_mem(0);

        // Reset with start held high.
        Reset   = 1'b1;
        start_r = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_we_n", 32'(a_we_n), 32'd1);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_all_done", 32'(a_all), 32'd0);
        chk("rst_seg", 32'(a_seg), 32'd0);
        chk("rst_rd_addr", 32'(a_rd_addr), 32'd0);
        Reset   = 1'b0;
        start_r = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(a_busy), 32'd0);

        // Instance A: table of expected writes, blocks run in order.
        cur = -1;
        for (int i = 0; i < 14; i++) begin
            while (cur < va[i].blk) begin
                cur++;
                set_mem(cur);
                run_block((cur == 39) ? 20 : 0);
                if (cur == 0) begin
                    chk("b0_write_count", 32'(w_cnt), 32'd32);
                    chk("b0_done_cycle", 32'(done_cyc), 32'd66);
                    chk("b0_last_write_cycle", 32'(w_cyc[31]), 32'd65);
                    chk("b0_rd_addr_seq_errs", 32'(rd_err), 32'd0);
                    errs = 0;
                    for (int j = 0; j < 32; j++) if (w_cyc[j] != 2 * j + 3) errs++;
                    chk("b0_write_timing_errs", 32'(errs), 32'd0);
                end
                if (cur == 39) begin
                    chk("b39_ign_start_count", 32'(w_cnt), 32'd32);
                    chk("b39_ign_start_done", 32'(done_cyc), 32'd66);
                end
                if (cur == 40) chk("b40_seg", 32'(seg_at), 32'd0);
            end
            chk($sformatf("a_blk%0d_w%0d_addr", va[i].blk, va[i].word),
                32'(w_addr[va[i].word]), 32'(va[i].addr));
            chk($sformatf("a_blk%0d_w%0d_data", va[i].blk, va[i].word),
                32'(w_data[va[i].word]), 32'(va[i].data));
        end

        // Reset in the middle of block 41: edge E0+30.
        set_mem(41);
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start_r = 1'b0;
            if (n == 30) Reset = 1'b1;
        end
        @(negedge clk);
        Reset = 1'b0;
        chk("midrst_we_n", 32'(a_we_n), 32'd1);
        chk("midrst_busy", 32'(a_busy), 32'd0);
        chk("midrst_rd_addr", 32'(a_rd_addr), 32'd0);
        chk("midrst_addr", 32'(a_addr), 32'd0);
        chk("midrst_data", 32'(a_data), 32'd0);
        errs = 0;
        repeat (4) begin
            @(negedge clk);
            if (!a_we_n || a_busy) errs++;
        end
        chk("midrst_quiet_errs", 32'(errs), 32'd0);
        run_block(0);
        chk("midrst_next_first_addr", 32'(w_addr[0]), 32'd0);
        chk("midrst_next_first_data", 32'(w_data[0]), 32'h0001);
        chk("midrst_next_count", 32'(w_cnt), 32'd32);

        // Instance B: small geometry, walks through all three segments.
        sel = 1'b1;
        cur = -1;
        for (int i = 0; i < 10; i++) begin
            while (cur < vb[i].blk) begin
                cur++;
                if (cur == 13) chk("b_all_done_before_last", 32'(b_all), 32'd0);
                run_block(0);
            end
            chk($sformatf("b_blk%0d_w%0d_addr", vb[i].blk, vb[i].word),
                32'(w_addr[vb[i].word]), 32'(vb[i].addr));
            chk($sformatf("b_blk%0d_seg", vb[i].blk), 32'(seg_at), 32'(vb[i].seg));
        end
        @(negedge clk);
        chk("b_all_done", 32'(b_all), 32'd1);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        errs = 0;
        repeat (6) begin
            @(negedge clk);
            if (b_busy || !b_we_n || !b_all) errs++;
        end
        chk("b_start_after_all_done_errs", 32'(errs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
